// File: rtl/rf_pkg.sv
// Shared definitions for the architectural register file: default sizes,
// the hardwired zero register index and common address/data types.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_ADDR_W = $clog2(DEF_NREGS);

  // Register x0 always reads as zero and ignores writes and issues.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file. The master side (decode and
// writeback) drives addresses, issue and write requests; the slave side
// (the register file) returns operand data, ready flags and the busy count.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
);

  logic [ADDR_W-1:0] reg1;
  logic [ADDR_W-1:0] reg2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              rdy1;
  logic              rdy2;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_rd;
  logic              RegWrite;
  logic [ADDR_W-1:0] regw;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output reg1, reg2, iss_en, iss_rd, RegWrite, regw, wdata,
    input  data1, data2, rdy1, rdy2, busy_cnt
  );

  modport slave (
    input  reg1, reg2, iss_en, iss_rd, RegWrite, regw, wdata,
    output data1, data2, rdy1, rdy2, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on
// writeback, plus a registered population count of the pending bits.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  output logic [NREGS-1:0]  pend_o,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam int CNT_W = ADDR_W + 1;

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic [CNT_W-1:0] busy_cnt_q;
  logic [CNT_W-1:0] busy_cnt_d;

  // Per-register next state: a new issue beats a same-cycle writeback,
  // since the issued instruction supersedes the completing one.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    if (gi == 0) begin : g_zero
      assign pend_d[gi] = 1'b0;
    end else begin : g_reg
      logic set_hit;
      logic clr_hit;
      assign set_hit    = set_en_i && (set_idx_i == ADDR_W'(gi));
      assign clr_hit    = clr_en_i && (clr_idx_i == ADDR_W'(gi));
      assign pend_d[gi] = set_hit || (pend_q[gi] && !clr_hit);
    end
  end

  // Count of pending registers after this edge, so busy_cnt tracks pend exactly.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(pend_d[i]);
    end
  end

  // Scoreboard state; asynchronous reset drops every pending write at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file: one synchronous write port, two combinational
// read ports with write-to-read bypass, and per-operand ready flags driven by
// the pending-write scoreboard. x0 is hardwired to zero.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NREGS     = DEF_NREGS,
  parameter int                ADDR_W    = $clog2(NREGS),
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  pend;
  logic              wr_en;
  logic              iss_vld;
  logic              byp_en;

  assign wr_en   = bus.RegWrite && (bus.regw != ADDR_W'(ZERO_REG));
  assign iss_vld = bus.iss_en && (bus.iss_rd != ADDR_W'(ZERO_REG));
  // While reset is held the outputs show the reset contents, so no bypass.
  assign byp_en  = bus.RegWrite && rst;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (iss_vld),
    .set_idx_i  (bus.iss_rd),
    .clr_en_i   (wr_en),
    .clr_idx_i  (bus.regw),
    .pend_o     (pend),
    .busy_cnt_o (bus.busy_cnt)
  );

  // Register storage; x0 is held at zero and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else if (wr_en) begin
      mem_q[bus.regw] <= bus.wdata;
    end
  end

  // One read port: {rdy, data}. x0 first, then bypass, then stored state.
  function automatic logic [DATA_W:0] rd_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] mem_val,
    input logic              pend_bit,
    input logic              byp,
    input logic [ADDR_W-1:0] byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    if (addr == ADDR_W'(ZERO_REG)) begin
      rd_port = {1'b1, {DATA_W{1'b0}}};
    end else if (byp && (byp_addr == addr)) begin
      rd_port = {1'b1, byp_data};
    end else begin
      rd_port = {!pend_bit, mem_val};
    end
  endfunction

  // Combinational operand reads for both decode ports.
  always_comb begin
    {bus.rdy1, bus.data1} = rd_port(bus.reg1, mem_q[bus.reg1], pend[bus.reg1],
                                    byp_en, bus.regw, bus.wdata);
    {bus.rdy2, bus.data2} = rd_port(bus.reg2, mem_q[bus.reg2], pend[bus.reg2],
                                    byp_en, bus.regw, bus.wdata);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: each cycle the driver applies inputs and
// pushes the reference model's expected outputs; a negedge monitor compares.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int          NR = 32;
  localparam int          DW = 32;
  localparam int          AW = 5;
  localparam logic [31:0] RV = 32'h2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(DW), .NREGS(NR)) rf_if ();

  reg_file_sb #(
    .DATA_W    (DW),
    .NREGS     (NR),
    .RESET_VAL (RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        r1;
    logic        r2;
    logic [AW:0] busy;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem_m [NR];
  bit          pend_m [NR];

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      mem_m[i]  = (i == 0) ? 32'h0 : RV;
      pend_m[i] = 1'b0;
    end
  endfunction

  function automatic int pend_count();
    int n = 0;
    for (int i = 0; i < NR; i++) if (pend_m[i]) n++;
    return n;
  endfunction

  // Reference read: x0 is zero; a live writeback to the address wins; else storage.
  function automatic void model_read(input int a, output logic [31:0] d, output logic r);
    if (a == 0) begin
      d = 32'h0; r = 1'b1;
    end else if (rst && rf_if.RegWrite && int'(rf_if.regw) == a) begin
      d = rf_if.wdata; r = 1'b1;
    end else begin
      d = mem_m[a]; r = !pend_m[a];
    end
  endfunction

  function automatic void push_expected(input string tag);
    exp_t e;
    e.tag = tag;
    model_read(int'(rf_if.reg1), e.d1, e.r1);
    model_read(int'(rf_if.reg2), e.d2, e.r2);
    e.busy = (AW+1)'(pend_count());
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("[%0t] %s r1=%0d r2=%0d d1=%h d2=%h rdy=%b%b busy=%0d", $time, e.tag,
                 rf_if.reg1, rf_if.reg2, rf_if.data1, rf_if.data2, rf_if.rdy1, rf_if.rdy2,
                 rf_if.busy_cnt);
        chk({e.tag, ".data1"}, rf_if.data1, e.d1);
        chk({e.tag, ".data2"}, rf_if.data2, e.d2);
        chk({e.tag, ".rdy1"}, 32'(rf_if.rdy1), 32'(e.r1));
        chk({e.tag, ".rdy2"}, 32'(rf_if.rdy2), 32'(e.r2));
        chk({e.tag, ".busy_cnt"}, 32'(rf_if.busy_cnt), 32'(e.busy));
      end
    end
  end

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input string tag, input int r1, input int r2, input bit iss,
                      input int ird, input bit we, input int wa, input logic [31:0] wd);
    rf_if.reg1     = AW'(r1);
    rf_if.reg2     = AW'(r2);
    rf_if.iss_en   = iss;
    rf_if.iss_rd   = AW'(ird);
    rf_if.RegWrite = we;
    rf_if.regw     = AW'(wa);
    rf_if.wdata    = wd;
    push_expected(tag);
    @(posedge clk);
    if (rst) begin
      if (we && wa != 0) begin
        mem_m[wa]  = wd;
        pend_m[wa] = 1'b0;
      end
      if (iss && ird != 0) pend_m[ird] = 1'b1;
    end
    #1;
  endtask

  initial begin
    int r1, r2, ird, wa, start;
    bit iss, we;

    rf_if.reg1 = '0; rf_if.reg2 = '0; rf_if.iss_en = 1'b0; rf_if.iss_rd = '0;
    rf_if.RegWrite = 1'b0; rf_if.regw = '0; rf_if.wdata = '0;
    model_reset();
    @(posedge clk); #1;

    // Held in reset: storage contents shown, no bypass, issues ignored.
    step("rst_hold", 0, 5, 1'b1, 6, 1'b1, 5, 32'hCAFE_0000);
    step("rst_hold2", 6, 5, 1'b0, 0, 1'b0, 0, 32'h0);
    rst = 1'b1;
    step("rst_read", 0, 5, 1'b0, 0, 1'b0, 0, 32'h0);

    step("wr_x7", 0, 1, 1'b0, 0, 1'b1, 7, 32'hDEAD_BEEF);
    step("rd_x7", 7, 7, 1'b0, 0, 1'b0, 0, 32'h0);
    step("wr_x0", 0, 7, 1'b0, 0, 1'b1, 0, 32'h0000_1234);
    step("rd_x0", 0, 0, 1'b0, 0, 1'b0, 0, 32'h0);
    step("bypass", 3, 3, 1'b0, 0, 1'b1, 3, 32'h0000_00A5);
    step("iss_x9", 9, 0, 1'b1, 9, 1'b0, 0, 32'h0);
    step("pend_x9", 9, 9, 1'b0, 0, 1'b0, 0, 32'h0);
    step("wb_x9", 9, 8, 1'b0, 0, 1'b1, 9, 32'h0000_0055);
    step("post_x9", 9, 0, 1'b0, 0, 1'b0, 0, 32'h0);
    step("iss_x4", 4, 0, 1'b1, 4, 1'b0, 0, 32'h0);
    step("collide", 4, 4, 1'b1, 4, 1'b1, 4, 32'h0000_0044);
    step("post_col", 4, 4, 1'b0, 0, 1'b0, 0, 32'h0);
    step("wb_x4", 4, 0, 1'b0, 0, 1'b1, 4, 32'h0000_0444);
    step("iss_x0", 0, 0, 1'b1, 0, 1'b0, 0, 32'h0);
    step("post_x0", 0, 0, 1'b0, 0, 1'b0, 0, 32'h0);

    // Random traffic; writebacks favour currently pending registers.
    for (int n = 0; n < 300; n++) begin
      r1  = int'($urandom_range(0, NR-1));
      r2  = int'($urandom_range(0, NR-1));
      iss = ($urandom_range(0, 2) == 0);
      ird = int'($urandom_range(0, NR-1));
      we  = ($urandom_range(0, 1) == 1);
      wa  = int'($urandom_range(0, NR-1));
      if ($urandom_range(0, 1) == 1) begin
        start = int'($urandom_range(0, NR-1));
        for (int k = 0; k < NR; k++) begin
          if (pend_m[(start + k) % NR]) begin
            wa = (start + k) % NR;
            break;
          end
        end
      end
      if ($urandom_range(0, 3) == 0) r1 = wa;
      step("rand", r1, r2, iss, ird, we, wa, $urandom);
    end

    // Three registers pending, then reset asserted mid-cycle.
    step("iss_x10", 0, 0, 1'b1, 10, 1'b0, 0, 32'h0);
    step("iss_x11", 10, 0, 1'b1, 11, 1'b1, 12, 32'h1212_1212);
    step("iss_x12", 10, 11, 1'b1, 12, 1'b0, 0, 32'h0);
    rf_if.reg1 = AW'(12); rf_if.reg2 = AW'(7);
    rf_if.iss_en = 1'b0; rf_if.RegWrite = 1'b0;
    #1;
    rst = 1'b0;
    model_reset();
    push_expected("async_rst");
    @(posedge clk); #1;
    step("rst_mid", 11, 9, 1'b0, 0, 1'b0, 0, 32'h0);
    rst = 1'b1;
    step("late_wb", 10, 11, 1'b0, 0, 1'b1, 10, 32'h0000_1010);
    step("after_late", 10, 11, 1'b0, 0, 1'b0, 0, 32'h0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
